// File: rtl/pw_multdiv_issue_pkg.sv
// rtl/pw_multdiv_issue_pkg.sv - shared opcodes, ALU op codes and FSM states for the PW mult/div path
// Purpose: constants and field helpers shared by the PW mult/div issue slice.
// Ports: none (package).
package pw_multdiv_issue_pkg;

  // Primary opcodes, IR[31:27]
  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;

  // ALU op codes, IR[6:2], valid with opcode OP_ALU
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  // Destination register used to report a multdiv exception
  localparam logic [4:0] RSTATUS_REG = 5'd30;

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, HOLD, WRITE} pwState_t;

  function automatic logic [4:0] opcodeOf(input logic [31:0] ir);
    return ir[31:27];
  endfunction

  function automatic logic [4:0] aluOpOf(input logic [31:0] ir);
    return ir[6:2];
  endfunction

endpackage

// File: rtl/pw_multdiv_issue_if.sv
// rtl/pw_multdiv_issue_if.sv - handshake bus between the PW issue logic and the multdiv unit
// Purpose: groups the start pulses, latched operands and result return of the multdiv unit.
// Ports (master = issue side):
//   ctrlMULT, ctrlDIV  master->slave  1-cycle start pulses
//   mdOpA, mdOpB       master->slave  operands, stable from issue until next issue
//   mdResultRDY        slave->master  result valid pulse
//   mdException        slave->master  overflow / divide-by-zero, valid with mdResultRDY
//   mdResult           slave->master  result data
interface pw_multdiv_issue_if #(parameter int WIDTH = 32);

  logic             ctrlMULT;
  logic             ctrlDIV;
  logic [WIDTH-1:0] mdOpA;
  logic [WIDTH-1:0] mdOpB;
  logic             mdResultRDY;
  logic             mdException;
  logic [WIDTH-1:0] mdResult;

  modport master (
    output ctrlMULT, ctrlDIV, mdOpA, mdOpB,
    input  mdResultRDY, mdException, mdResult
  );

  modport slave (
    input  ctrlMULT, ctrlDIV, mdOpA, mdOpB,
    output mdResultRDY, mdException, mdResult
  );

endinterface

// File: rtl/pw_hazard_check.sv
// rtl/pw_hazard_check.sv - combinational mult/div decode, write-slot and hazard check
// Purpose: decodes mult/div in X, detects a W-stage register write, and raises the
//          front-end stall on structural or RAW hazards against the in-flight op.
// Ports:
//   dxIR      in  32  X-stage instruction
//   mwIR      in  32  W-stage instruction
//   pwRd      in  5   destination of the in-flight op (PWIR[26:22])
//   active    in  1   an op is in flight (FSM not idle)
//   isMD      out 1   X-stage instruction is mult or div
//   mwWrites  out 1   W stage uses the register-file write port this cycle
//   stallFDX  out 1   hold PC, F/D and D/X
module pw_hazard_check
  import pw_multdiv_issue_pkg::*;
(
  input  logic [31:0] dxIR,
  input  logic [31:0] mwIR,
  input  logic [4:0]  pwRd,
  input  logic        active,
  output logic        isMD,
  output logic        mwWrites,
  output logic        stallFDX
);

  logic [4:0] mwOp;
  logic       rawHit;
  logic       unusedBits;

  assign isMD = (opcodeOf(dxIR) == OP_ALU) &&
                ((aluOpOf(dxIR) == ALUOP_MULT) || (aluOpOf(dxIR) == ALUOP_DIV));

  assign mwOp     = opcodeOf(mwIR);
  assign mwWrites = (mwOp == OP_ALU) || (mwOp == OP_JAL) ||
                    (mwOp == OP_ADDI) || (mwOp == OP_LW);

  // Conservative: any non-zero rd/rs/rt field matching the pending destination
  // stalls, regardless of whether the instruction actually reads that field.
  assign rawHit = (pwRd != 5'd0) &&
                  ((dxIR[26:22] == pwRd) || (dxIR[21:17] == pwRd) ||
                   (dxIR[16:12] == pwRd));

  assign stallFDX = active && (isMD || rawHit);

  assign unusedBits = ^{dxIR[11:7], dxIR[1:0], mwIR[26:0]};

endmodule

// File: rtl/pw_multdiv_issue.sv
// rtl/pw_multdiv_issue.sv - PW-stage mult/div issue, sequencing and writeback producer
// Purpose: takes mult/div out of X, sequences the external multdiv unit, holds the
//          result and pulses multOrDivReady once when the W stage is not writing.
// Ports:
//   clock, resetN     clock and asynchronous active-low reset
//   DXIR, DXOpA/B     X-stage instruction and bypassed operands
//   MWIR              W-stage instruction (write-slot check)
//   md                multdiv unit bus (master side)
//   PWIR, pwResult    latched IR (rd rewritten on exception) and writeback data
//   multOrDivReady    1-cycle PW write pulse
//   xmInsertNop       X/M latch loads a nop this cycle
//   stallFDX          hold PC, F/D and D/X
module pw_multdiv_issue
  import pw_multdiv_issue_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic [31:0]        DXIR,
  input  logic [WIDTH-1:0]   DXOpA,
  input  logic [WIDTH-1:0]   DXOpB,
  input  logic [31:0]        MWIR,
  pw_multdiv_issue_if.master md,
  output logic [31:0]        PWIR,
  output logic [WIDTH-1:0]   pwResult,
  output logic               multOrDivReady,
  output logic               xmInsertNop,
  output logic               stallFDX
);

  localparam int CW = $clog2(TIMEOUT);

  pwState_t         state, nextState;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] opA, opB;
  logic             isMD, mwWrites;
  logic             isDivOp, timedOut, issueNow;
  logic             startMult, startDiv;
  logic [WIDTH-1:0] excValue;

  pw_hazard_check hazard (
    .dxIR     (DXIR),
    .mwIR     (MWIR),
    .pwRd     (PWIR[26:22]),
    .active   (state != IDLE),
    .isMD     (isMD),
    .mwWrites (mwWrites),
    .stallFDX (stallFDX)
  );

  assign isDivOp  = (aluOpOf(PWIR) == ALUOP_DIV);
  assign timedOut = (counter == CW'(TIMEOUT - 1));
  assign excValue = isDivOp ? WIDTH'(5) : WIDTH'(4);

  always_comb begin
    nextState      = state;
    issueNow       = 1'b0;
    startMult      = 1'b0;
    startDiv       = 1'b0;
    multOrDivReady = 1'b0;
    case (state)
      IDLE: begin
        if (isMD) begin
          issueNow  = 1'b1;
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        startMult = !isDivOp;
        startDiv  = isDivOp;
        nextState = BUSY;
      end
      BUSY: begin
        if (md.mdResultRDY || timedOut) nextState = mwWrites ? HOLD : WRITE;
      end
      HOLD: begin
        if (!mwWrites) nextState = WRITE;
      end
      WRITE: begin
        if (!mwWrites) begin
          multOrDivReady = 1'b1;
          nextState      = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Gated by resetN so every output reads 0 while reset is held, even with a
  // mult/div sitting in X.
  assign xmInsertNop = resetN && (issueNow || stallFDX);

  assign md.ctrlMULT = startMult;
  assign md.ctrlDIV  = startDiv;
  assign md.mdOpA    = opA;
  assign md.mdOpB    = opB;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      counter  <= '0;
      PWIR     <= '0;
      opA      <= '0;
      opB      <= '0;
      pwResult <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (issueNow) begin
            PWIR <= DXIR;
            opA  <= DXOpA;
            opB  <= DXOpB;
          end
        end
        ISSUE: counter <= '0;
        BUSY: begin
          // A real result in the expiry cycle takes precedence over the watchdog.
          if (md.mdResultRDY) begin
            if (md.mdException) begin
              PWIR[26:22] <= RSTATUS_REG;
              pwResult    <= excValue;
            end else begin
              pwResult <= md.mdResult;
            end
          end else if (timedOut) begin
            PWIR[26:22] <= RSTATUS_REG;
            pwResult    <= excValue;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pw_multdiv_issue.sv
// tb/tb_pw_multdiv_issue.sv - self-checking bench for pw_multdiv_issue
module tb_pw_multdiv_issue;
  import pw_multdiv_issue_pkg::*;

  localparam int W  = 32;
  localparam int TO = 64;

  logic          clock;
  logic          resetN;
  logic [31:0]   DXIR, MWIR, PWIR;
  logic [W-1:0]  DXOpA, DXOpB, pwResult;
  logic          multOrDivReady, xmInsertNop, stallFDX;

  pw_multdiv_issue_if #(.WIDTH(W)) mdBus ();

  pw_multdiv_issue #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock          (clock),
    .resetN         (resetN),
    .DXIR           (DXIR),
    .DXOpA          (DXOpA),
    .DXOpB          (DXOpB),
    .MWIR           (MWIR),
    .md             (mdBus.master),
    .PWIR           (PWIR),
    .pwResult       (pwResult),
    .multOrDivReady (multOrDivReady),
    .xmInsertNop    (xmInsertNop),
    .stallFDX       (stallFDX)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] res;
    logic        isDiv;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] swIR, addiIR;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkR(input logic [4:0] rd, rs, rt, aluop);
    return {5'd0, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  function automatic bit isMdM(input logic [31:0] ir);
    return (ir[31:27] == 5'd0) && (ir[6:2] == ALUOP_MULT || ir[6:2] == ALUOP_DIV);
  endfunction

  function automatic bit mwWritesM(input logic [31:0] ir);
    return ir[31:27] inside {5'd0, 5'd3, 5'd5, 5'd8};
  endfunction

  function automatic bit hazM(input logic [31:0] dx, input logic [4:0] rd);
    return isMdM(dx) ||
           (rd != 5'd0 && (dx[26:22] == rd || dx[21:17] == rd || dx[16:12] == rd));
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every start pulse must carry the head op's operands, every
  // ready pulse must deliver the head op's result and IR in a free write slot.
  always @(negedge clock) begin
    if (resetN) begin
      if (mdBus.ctrlMULT || mdBus.ctrlDIV) begin
        if (sb.size() == 0) chk("startUnexpected", {mdBus.ctrlMULT, mdBus.ctrlDIV}, 0);
        else begin
          chk("startKind", mdBus.ctrlDIV, sb[0].isDiv);
          chk("startBoth", mdBus.ctrlMULT & mdBus.ctrlDIV, 0);
          chk("startOpA", mdBus.mdOpA, sb[0].a);
          chk("startOpB", mdBus.mdOpB, sb[0].b);
        end
      end
      if (multOrDivReady) begin
        if (sb.size() == 0) chk("readyUnexpected", multOrDivReady, 0);
        else begin
          chk("readyResult", pwResult, sb[0].res);
          chk("readyPWIR", PWIR, sb[0].ir);
          chk("readyWriteSlotFree", mwWritesM(MWIR), 0);
          void'(sb.pop_front());
        end
      end
    end
  end

  // One complete mult/div: issue from IDLE, result 'delay' cycles after the
  // start pulse (or never), W stage busy for mwBusy cycles from the result
  // cycle, dx held in X from the start cycle onward.
  task automatic doOp(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                      input int delay, input bit giveRdy, input bit exc, input int mwBusy,
                      input logic [31:0] dx, input logic [31:0] litRes, input logic [4:0] litRd);
    exp_t        e;
    bit          isDiv, fault, hz;
    int          r, readyCyc;
    logic [4:0]  rdCur;
    logic [31:0] raw;
    isDiv   = (ir[6:2] == ALUOP_DIV);
    fault   = exc || !giveRdy;
    e.isDiv = isDiv;
    e.a     = a;
    e.b     = b;
    e.ir    = ir;
    if (fault) begin
      e.res        = isDiv ? 32'd5 : 32'd4;
      e.ir[26:22]  = 5'd30;
    end else begin
      e.res = isDiv ? a / b : a * b;
    end
    raw = isDiv ? ((b == 0) ? 32'hffff_ffff : a / b) : a * b;
    sb.push_back(e);

    DXIR = ir; DXOpA = a; DXOpB = b; MWIR = swIR;
    @(negedge clock);
    chk("issueNop", xmInsertNop, 1);
    chk("issueNoStall", stallFDX, 0);
    tick();
    DXIR = dx; DXOpA = 32'hdead_beef; DXOpB = 32'h1234_5678;
    @(negedge clock);
    chk("startPulse", isDiv ? mdBus.ctrlDIV : mdBus.ctrlMULT, 1);
    chk("stallAtStart", stallFDX, hazM(dx, ir[26:22]));

    r        = 1 + delay;
    readyCyc = r + 1 + mwBusy;
    for (int cyc = 2; cyc <= readyCyc; cyc++) begin
      tick();
      mdBus.mdResultRDY = giveRdy && (cyc == r);
      mdBus.mdException = exc && (cyc == r);
      mdBus.mdResult    = (cyc == r) ? raw : 32'd0;
      MWIR = (cyc >= r && cyc < r + mwBusy) ? addiIR : swIR;
      @(negedge clock);
      rdCur = (cyc > r) ? e.ir[26:22] : ir[26:22];
      hz    = hazM(dx, rdCur);
      chk("stall", stallFDX, hz);
      chk("xmNop", xmInsertNop, hz);
      chk("readyTiming", multOrDivReady, cyc == readyCyc);
      chk("noRestart", mdBus.ctrlMULT | mdBus.ctrlDIV, 0);
    end
    chk("litResult", pwResult, litRes);
    chk("litRd", PWIR[26:22], litRd);
    tick();
    if (!isMdM(dx)) begin
      @(negedge clock);
      chk("releaseStall", stallFDX, 0);
      chk("releaseNop", xmInsertNop, 0);
      chk("singlePulse", multOrDivReady, 0);
      tick();
      DXIR = 32'd0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL globalTimeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    swIR   = {OP_SW, 5'd1, 5'd2, 17'd0};
    addiIR = {OP_ADDI, 5'd5, 5'd0, 17'd1};

    // Reset with a mult sitting in X: everything must read 0
    resetN = 1'b0;
    DXIR = mkR(5'd3, 5'd1, 5'd2, ALUOP_MULT);
    DXOpA = 32'd6; DXOpB = 32'd7; MWIR = swIR;
    mdBus.mdResultRDY = 1'b0; mdBus.mdException = 1'b0; mdBus.mdResult = '0;
    tick(); tick();
    @(negedge clock);
    chk("rstCtrlMULT", mdBus.ctrlMULT, 0);
    chk("rstCtrlDIV", mdBus.ctrlDIV, 0);
    chk("rstOpA", mdBus.mdOpA, 0);
    chk("rstOpB", mdBus.mdOpB, 0);
    chk("rstPWIR", PWIR, 0);
    chk("rstResult", pwResult, 0);
    chk("rstReady", multOrDivReady, 0);
    chk("rstNop", xmInsertNop, 0);
    chk("rstStall", stallFDX, 0);
    tick();
    resetN = 1'b1; DXIR = 32'd0;
    tick();

    // mult r3,r1,r2 6*7, result 17 cycles after start
    doOp(mkR(5'd3, 5'd1, 5'd2, ALUOP_MULT), 32'd6, 32'd7, 17, 1, 0, 0, 32'd0, 32'd42, 5'd3);
    // W stage writing for 2 cycles when the result lands
    doOp(mkR(5'd8, 5'd1, 5'd2, ALUOP_MULT), 32'd100, 32'd3, 5, 1, 0, 2, 32'd0, 32'd300, 5'd8);
    // div by zero
    doOp(mkR(5'd4, 5'd1, 5'd2, ALUOP_DIV), 32'd9, 32'd0, 6, 1, 1, 0, 32'd0, 32'd5, 5'd30);
    // normal div
    doOp(mkR(5'd9, 5'd1, 5'd2, ALUOP_DIV), 32'd100, 32'd7, 3, 1, 0, 0, 32'd0, 32'd14, 5'd9);
    // RAW: add r6,r3,r1 while rd=3 in flight
    doOp(mkR(5'd3, 5'd1, 5'd2, ALUOP_MULT), 32'd5, 32'd5, 4, 1, 0, 0,
         mkR(5'd6, 5'd3, 5'd1, 5'd0), 32'd25, 5'd3);
    // Structural: mult r7 waits, then issues back-to-back
    doOp(mkR(5'd3, 5'd1, 5'd2, ALUOP_MULT), 32'd2, 32'd3, 2, 1, 0, 0,
         mkR(5'd7, 5'd1, 5'd2, ALUOP_MULT), 32'd6, 5'd3);
    doOp(mkR(5'd7, 5'd1, 5'd2, ALUOP_MULT), 32'd4, 32'd4, 3, 1, 0, 0, 32'd0, 32'd16, 5'd7);
    // rd=0 still runs the whole sequence
    doOp(mkR(5'd0, 5'd1, 5'd2, ALUOP_MULT), 32'd2, 32'd2, 2, 1, 0, 1, 32'd0, 32'd4, 5'd0);
    // Watchdog expiry on mult and div
    doOp(mkR(5'd3, 5'd1, 5'd2, ALUOP_MULT), 32'd1, 32'd1, TO, 0, 0, 0, 32'd0, 32'd4, 5'd30);
    doOp(mkR(5'd2, 5'd1, 5'd3, ALUOP_DIV), 32'd8, 32'd2, TO, 0, 0, 0, 32'd0, 32'd5, 5'd30);
    // Result in the last cycle before expiry, and exactly at expiry
    doOp(mkR(5'd5, 5'd1, 5'd2, ALUOP_MULT), 32'd3, 32'd3, TO - 1, 1, 0, 0, 32'd0, 32'd9, 5'd5);
    doOp(mkR(5'd5, 5'd1, 5'd2, ALUOP_MULT), 32'd3, 32'd4, TO, 1, 0, 0, 32'd0, 32'd12, 5'd5);

    // Reset while BUSY
    begin
      exp_t e;
      e.ir = mkR(5'd3, 5'd1, 5'd2, ALUOP_MULT); e.a = 32'd11; e.b = 32'd12;
      e.isDiv = 1'b0; e.res = 32'd132;
      sb.push_back(e);
      DXIR = e.ir; DXOpA = e.a; DXOpB = e.b;
      tick();
      DXIR = 32'd0;
      tick(); tick(); tick();
      resetN = 1'b0;
      sb.delete();
      @(negedge clock);
      chk("midRstPWIR", PWIR, 0);
      chk("midRstOpA", mdBus.mdOpA, 0);
      chk("midRstOpB", mdBus.mdOpB, 0);
      chk("midRstResult", pwResult, 0);
      chk("midRstReady", multOrDivReady, 0);
      chk("midRstCtrl", mdBus.ctrlMULT | mdBus.ctrlDIV, 0);
      tick();
      resetN = 1'b1;
      tick();
      mdBus.mdResultRDY = 1'b1; mdBus.mdResult = 32'd132;
      tick();
      mdBus.mdResultRDY = 1'b0; mdBus.mdResult = 32'd0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        chk("noReadyAfterRst", multOrDivReady, 0);
        chk("noStallAfterRst", stallFDX, 0);
        tick();
      end
    end
    doOp(mkR(5'd3, 5'd1, 5'd2, ALUOP_MULT), 32'd6, 32'd7, 17, 1, 0, 0, 32'd0, 32'd42, 5'd3);

    chk("scoreboardDrained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
